// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package instr_fetch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2,
        ERR     = 2'd3
    } fetch_state_e;

    localparam int          WORD_BYTES       = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } fq_entry_t;

    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + 32'(WORD_BYTES);
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between fetch unit and memory.
interface instr_fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] data;

    modport master (output req, output addr, input ack, input data);
    modport slave  (input req, input addr, output ack, output data);
endinterface

// File: rtl/instr_fetch_unit_fetch_queue.sv
// Two-entry FIFO of fetched {instr, pc4}; head is zero whenever the queue is empty.
module fetch_queue
    import instr_fetch_unit_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push_i,
    input  logic      pop_i,
    input  logic      flush_i,
    input  fq_entry_t wdata_i,
    output logic [1:0] count_o,
    output fq_entry_t head_o
);
    fq_entry_t  ent0_q;
    fq_entry_t  ent1_q;
    logic [1:0] cnt_q;

    // ent0_q is always the head; a pop shifts ent1_q forward.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0_q <= '0;
            ent1_q <= '0;
            cnt_q  <= 2'd0;
        end else if (flush_i) begin
            cnt_q <= 2'd0;
        end else begin
            case ({push_i, pop_i})
                2'b10: begin
                    if (cnt_q == 2'd0) ent0_q <= wdata_i;
                    else               ent1_q <= wdata_i;
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    ent0_q <= ent1_q;
                    cnt_q  <= cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd2) begin
                        ent0_q <= ent1_q;
                        ent1_q <= wdata_i;
                    end else begin
                        ent0_q <= wdata_i;
                    end
                end
                default: ;
            endcase
        end
    end

    assign count_o = cnt_q;
    assign head_o  = (cnt_q != 2'd0) ? ent0_q : '0;
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues word fetches, buffers returns and drives IF/ID load/flush.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          TIMEOUT  = 255,
    parameter int          CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_fetch_unit_if.master imem,
    input  logic               stall_i,
    input  logic               br_taken_i,
    input  logic [31:0]        br_target_i,
    output logic [31:0]        instr_o,
    output logic [31:0]        pc4_o,
    output logic               ifid_le_o,
    output logic               ifid_clr_o,
    output logic               fetch_err_o
);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    fetch_state_e     state_q;
    logic [31:0]      pc_q;
    logic [31:0]      hold_addr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pend_q;

    logic       issue_pop, req, q_push, q_pop, q_flush;
    logic [1:0] q_count, q_occ;
    fq_entry_t  q_head, q_wdata;

    // Issue looks at occupancy after this cycle's potential pop, independent of redirect.
    always_comb begin
        issue_pop = (q_count != 2'd0) && !stall_i;
        q_occ     = q_count - {1'b0, issue_pop};
        req       = 1'b0;
        case (state_q)
            FETCH:   req = pend_q || (q_occ != 2'd2);
            DISCARD: req = 1'b1;
            default: req = 1'b0;
        endcase
        q_pop         = issue_pop && !br_taken_i && (state_q != ERR);
        q_push        = (state_q == FETCH) && req && imem.ack && !br_taken_i;
        q_flush       = br_taken_i && (state_q != ERR);
        q_wdata.instr = imem.data;
        q_wdata.pc4   = next_pc(pc_q);
    end

    assign imem.req  = req;
    assign imem.addr = (state_q == DISCARD) ? hold_addr_q : pc_q;

    // In DISCARD pc_q already holds the redirect target while hold_addr_q keeps the bus stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            hold_addr_q <= '0;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: state_q <= FETCH;
                FETCH: begin
                    if (req && imem.ack) begin
                        cnt_q  <= '0;
                        pend_q <= 1'b0;
                        pc_q   <= br_taken_i ? br_target_i : next_pc(pc_q);
                    end else if (req && (cnt_q == TIMEOUT_LAST)) begin
                        state_q <= ERR;
                        pend_q  <= 1'b0;
                    end else if (req) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (br_taken_i) begin
                            hold_addr_q <= pc_q;
                            pc_q        <= br_target_i;
                            pend_q      <= 1'b0;
                            state_q     <= DISCARD;
                        end else begin
                            pend_q <= 1'b1;
                        end
                    end else if (br_taken_i) begin
                        pc_q <= br_target_i;
                    end
                end
                DISCARD: begin
                    if (br_taken_i) pc_q <= br_target_i;
                    if (imem.ack) begin
                        cnt_q   <= '0;
                        state_q <= FETCH;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_q <= ERR;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= ERR;
            endcase
        end
    end

    fetch_queue u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (q_push),
        .pop_i   (q_pop),
        .flush_i (q_flush),
        .wdata_i (q_wdata),
        .count_o (q_count),
        .head_o  (q_head)
    );

    assign instr_o     = q_head.instr;
    assign pc4_o       = q_head.pc4;
    assign ifid_le_o   = q_pop;
    assign ifid_clr_o  = br_taken_i;
    assign fetch_err_o = (state_q == ERR);
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed + randomized bench for instr_fetch_unit against a stream-level reference model.
module tb_instr_fetch_unit;
    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, brTaken;
    logic [31:0] brTarget;
    logic [31:0] instrOut, pc4Out;
    logic        ifidLe, ifidClr, fetchErr;

    instr_fetch_unit_if imemIf();

    instr_fetch_unit #(.RESET_PC(32'h0), .TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem        (imemIf),
        .stall_i     (stall),
        .br_taken_i  (brTaken),
        .br_target_i (brTarget),
        .instr_o     (instrOut),
        .pc4_o       (pc4Out),
        .ifid_le_o   (ifidLe),
        .ifid_clr_o  (ifidClr),
        .fetch_err_o (fetchErr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: program-order stream of word addresses plus buffered-word count.
    logic [31:0] expPc, nextFetch, reqAddr;
    int          occ, waitCnt, latency, minLat, maxLat;
    bit          pending, discarding, errState, startup;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (a == 32'h0) return 32'hE081_0002;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        rst_n = 1'b0; stall = 1'b0; brTaken = 1'b0; brTarget = '0;
        imemIf.ack = 1'b0; imemIf.data = '0;
        #1;
        checkOutput("rst_req", 32'(imemIf.req), 32'h0);
        checkOutput("rst_le", 32'(ifidLe), 32'h0);
        checkOutput("rst_clr", 32'(ifidClr), 32'h0);
        checkOutput("rst_instr", instrOut, 32'h0);
        checkOutput("rst_pc4", pc4Out, 32'h0);
        checkOutput("rst_err", 32'(fetchErr), 32'h0);
        expPc = 32'h0; nextFetch = 32'h0; reqAddr = 32'h0;
        occ = 0; waitCnt = 0; latency = 0;
        pending = 1'b0; discarding = 1'b0; errState = 1'b0; startup = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One clock cycle: drive inputs, play memory, check outputs, advance the model.
    task automatic applyStimulus(input bit stallIn, input bit brIn, input logic [31:0] tgt);
        bit expReq, ackNow, expLe;
        int popRaw;
        stall = stallIn; brTaken = brIn; brTarget = tgt;
        imemIf.ack = 1'b0; imemIf.data = '0;
        #1;
        popRaw = (occ > 0 && !stallIn) ? 1 : 0;
        if (errState || startup) expReq = 1'b0;
        else if (pending)        expReq = 1'b1;
        else                     expReq = (occ - popRaw) < 2;
        checkOutput("imem_req", 32'(imemIf.req), 32'(expReq));
        if (expReq) begin
            if (!pending) begin
                reqAddr = nextFetch;
                latency = int'($urandom_range(maxLat, minLat));
                waitCnt = 0;
            end
            checkOutput("imem_addr", imemIf.addr, reqAddr);
        end
        if (imemIf.req) begin
            ackNow = (waitCnt >= latency);
            imemIf.data = memWord(imemIf.addr);
        end else begin
            ackNow = ($urandom_range(0, 3) == 0);
            imemIf.data = $urandom;
        end
        imemIf.ack = ackNow;
        #1;
        expLe = (occ > 0) && !stallIn && !brIn && !errState;
        checkOutput("ifid_clr", 32'(ifidClr), 32'(brIn));
        checkOutput("ifid_le", 32'(ifidLe), 32'(expLe));
        checkOutput("instr_out", instrOut, (occ > 0) ? memWord(expPc) : 32'h0);
        checkOutput("pc4_out", pc4Out, (occ > 0) ? expPc + 32'd4 : 32'h0);
        checkOutput("fetch_err", 32'(fetchErr), 32'(errState));

        startup = 1'b0;
        if (!errState) begin
            if (expReq) begin
                if (ackNow) begin
                    if (!brIn && !discarding) begin
                        occ++;
                        nextFetch = nextFetch + 32'd4;
                    end
                    discarding = 1'b0;
                    pending = 1'b0;
                end else begin
                    pending = 1'b1;
                    waitCnt++;
                    if (brIn) discarding = 1'b1;
                    if (waitCnt == TIMEOUT) begin
                        errState = 1'b1;
                        pending = 1'b0;
                        discarding = 1'b0;
                    end
                end
            end
            if (brIn) begin
                occ = 0;
                expPc = tgt;
                nextFetch = tgt;
            end else if (expLe) begin
                occ--;
                expPc = expPc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit          rs, rb;
        logic [31:0] rt;
        int          guard;

        minLat = 0; maxLat = 0;
        doReset();

        $display("[TB] zero-wait fill and sustained fetch");
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b0, 32'h0);

        $display("[TB] stall holds queue at two entries");
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("stall_occ", 32'(occ), 32'd2);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 32'h0);

        $display("[TB] redirect with slow request outstanding");
        minLat = 3; maxLat = 3;
        guard = 0;
        while (!pending && guard < 10) begin
            applyStimulus(1'b0, 1'b0, 32'h0);
            guard++;
        end
        checkOutput("pend_bound", 32'(pending), 32'h1);
        applyStimulus(1'b0, 1'b1, 32'h0000_0100);
        for (int i = 0; i < 14; i++) applyStimulus(1'b0, 1'b0, 32'h0);

        $display("[TB] redirect together with stall on a full queue");
        minLat = 0; maxLat = 0;
        guard = 0;
        while (occ < 2 && guard < 10) begin
            applyStimulus(1'b1, 1'b0, 32'h0);
            guard++;
        end
        checkOutput("full_bound", 32'(occ), 32'd2);
        applyStimulus(1'b1, 1'b1, 32'h0000_0200);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 32'h0);

        $display("[TB] PC wrap at top of address space");
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF8);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 32'h0);

        $display("[TB] randomized traffic");
        minLat = 0; maxLat = 3;
        for (int i = 0; i < 400; i++) begin
            rs = ($urandom_range(0, 9) < 3);
            rb = ($urandom_range(0, 19) == 0);
            rt = $urandom & 32'h0000_0FFC;
            applyStimulus(rs, rb, rt);
        end

        $display("[TB] reset while a request is outstanding");
        minLat = 5; maxLat = 5;
        guard = 0;
        while (!pending && guard < 10) begin
            applyStimulus(1'b0, 1'b0, 32'h0);
            guard++;
        end
        checkOutput("pend_bound2", 32'(pending), 32'h1);
        doReset();
        minLat = 0; maxLat = 2;
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 32'h0);

        $display("[TB] acknowledge withheld until timeout");
        minLat = 1000; maxLat = 1000;
        guard = 0;
        while (!errState && guard < 300) begin
            applyStimulus(1'b0, 1'b0, 32'h0);
            guard++;
        end
        checkOutput("timeout_bound", 32'(errState), 32'h1);
        for (int i = 0; i < 5; i++) applyStimulus(i[0], 1'b0, 32'h0);
        checkOutput("err_sticky", 32'(fetchErr), 32'h1);
        checkOutput("err_req", 32'(imemIf.req), 32'h0);
        doReset();
        minLat = 0; maxLat = 0;
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
